wbc_hex_scan: RTL and testbench
===============================

# wbc_hex_scan

Parametrised multiplexed seven-segment display scanner for the board tops. It holds a per-digit display register file and scans DIGITS common-select lines from an external enable strobe. It adds per-digit hex decode or raw segment mode, per-digit blanking, PWM brightness control and an anti-ghosting guard cycle. It replaces the hand-coded three-digit select counter in each board top and is fed by the CPU wrapper's ms/us strobes.

## Interface
- DIGITS, 3: number of digits scanned, 1..8.
- DIM_BITS, 3: width of the brightness control and the PWM phase counter.
- SEG_ACT, 0: active level of segment outputs (0 = active-low).
- SEL_ACT, 0: active level of digit-select outputs.

- clk  in  1  system clock (sys_clk_p).
- rst_n  in  1  reset, asynchronous, active-low.
- ena_tick  in  1  single-cycle scan advance strobe (typically ena_ms).
- wr_stb  in  1  single-cycle digit register write strobe.
- wr_idx  in  3  digit index to write; values >= DIGITS are ignored.
- wr_raw  in  1  written digit mode: 0 = hex decode, 1 = raw segments.
- wr_dat  in  8  hex mode: [3:0] nibble, [7] dp; raw mode: segments {dp,g,f,e,d,c,b,a}.
- blank  in  DIGITS  per-digit blank mask; 1 = digit dark in its slot.
- dim  in  DIM_BITS  brightness; all-ones = 100% duty.
- hex_seg  out  8  segment drive {dp,g..a}, registered, SEG_ACT polarity.
- hex_sel  out  DIGITS  one-hot digit select, registered, SEL_ACT polarity.

## Operation
- Register file: DIGITS entries of {raw, dat[7:0]}.
  - Reset value of every entry: raw=1, dat=0x00, so all digits are dark.
  - wr_stb with wr_idx < DIGITS loads {wr_raw, wr_dat} into entry wr_idx.
- Decode, with segment bit 0 = a:
  - Hex mode: 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66, 5→0x6D, 6→0x7D, 7→0x07, 8→0x7F, 9→0x6F, A→0x77, b→0x7C, C→0x39, d→0x5E, E→0x79, F→0x71.
  - Bit 7 = wr_dat[7] (dp).
  - Raw mode: dat used unchanged.
- Scan index `slot` counts 0,1,..,DIGITS-1 and wraps to 0. It advances on each ena_tick.
- Guard: for the one cycle after a slot change, all selects and all segments are inactive.
- PWM: `phase` is a free-running DIM_BITS counter that increments every clk and wraps.
  - Digit is lit when phase <= dim and blank[slot]==0.
  - Otherwise the select is inactive and the segments are inactive.
- Polarity: logical-1 segment/select values are XORed with ~SEG_ACT / ~SEL_ACT before the output registers.
- DIGITS==1: slot is fixed at 0, ena_tick still produces a guard cycle.

## Timing
- Reset (async assert): hex_seg = all-inactive (8{~SEG_ACT}), hex_sel = all-inactive, slot=0, phase=0, guard=0, register file blank.
- Deassert: first lit output appears 1 cycle after a written digit's slot is active.
- Write latency: wr_stb at cycle N updates the register at N+1 and the outputs at N+2, if that slot is active and lit.
- ena_tick at cycle N:
  - slot updates at N+1 and outputs are inactive at N+1 (guard).
  - The new digit drives at N+2.
- ena_tick during a guard cycle: slot advances again and the guard is re-armed. Outputs are never driven for a skipped digit.
- wr_stb and ena_tick in the same cycle: both take effect. The write targets the entry, not the slot.
- A write to the currently displayed slot changes segments glitch-free. Registered outputs change only at clock edges.
- blank and dim are sampled every cycle; a change is visible 1 cycle later.
- Reset asserted mid-scan: all outputs go inactive asynchronously with no clock required.

## Structure
- Shared header `wbc_hex_defs.vh`:
  - 16-entry hex→segment table.
  - Segment bit position constants (SEG_A..SEG_DP).
  - Reset/blank segment constant.
- Sub-module `wbc_hex_dec`: combinational, nibble + dp + raw + dat in, 8-bit logical segments out. It is reused by other display blocks.
- Top holds the register file, slot/phase/guard counters and the output registers. Estimated size is ~150-200 lines.

## Test plan
- Reset check: assert rst_n=0 mid-scan with SEG_ACT=0, SEL_ACT=0 → hex_seg=0xFF and hex_sel=3'b111 immediately. After release, with no writes, outputs stay inactive for all slots.
- Hex decode: DIGITS=3, dim=7, write idx0=0x08, idx1=0x8A, idx2 raw 0x49, then tick through all slots. Each slot shows 0x80, 0x08, 0xB6 respectively (active-low of 0x7F, 0xF7, 0x49), with its select low.
- Guard and wrap: ena_tick at N → slot 0→1, all outputs inactive at N+1, digit 1 driven at N+2. After three ticks slot wraps to 0.
- PWM: dim=1, DIM_BITS=3 → select active exactly 2 of every 8 cycles (phase 0,1). dim=7 → 8 of 8. blank[slot]=1 → 0 of 8.
- Edge cases: write with wr_idx=3 at DIGITS=3 → no register changes. Simultaneous wr_stb to idx1 and ena_tick from slot 0 → digit 1 shows the new value at its first lit cycle.
- Parameter sweep: DIGITS=1 and DIGITS=8 with SEG_ACT=1, SEL_ACT=1 → correct wrap (slot 7→0), positive-polarity outputs, all-zero outputs in reset.

Source files
------------

// File: rtl/wbc_hex_scan_pkg.sv
// Shared seven-segment definitions: hex table, segment bit positions, and the
// register-file entry type used by the scanner and other display blocks.
package wbc_hex_scan_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Logical (active-high) segments that are all dark.
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Index n holds the pattern for nibble n, bit 0 = segment a.
  localparam logic [15:0][7:0] HEX_LUT = {
    8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
    8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };

  typedef struct packed {
    logic       raw;
    logic [7:0] dat;
  } digit_t;

  // Raw mode with no segments set: the digit stays dark until written.
  localparam digit_t DIGIT_RST = '{raw: 1'b1, dat: 8'h00};

endpackage

// File: rtl/wbc_hex_scan_if.sv
// Host-side bus of the display scanner: write port, scan strobe, brightness
// and blanking controls, plus the registered display drive.
interface wbc_hex_scan_if #(
  parameter int DIGITS   = 3,
  parameter int DIM_BITS = 3
);
  logic                ena_tick;
  logic                wr_stb;
  logic [2:0]          wr_idx;
  logic                wr_raw;
  logic [7:0]          wr_dat;
  logic [DIGITS-1:0]   blank;
  logic [DIM_BITS-1:0] dim;
  logic [7:0]          hex_seg;
  logic [DIGITS-1:0]   hex_sel;

  modport master (
    output ena_tick, wr_stb, wr_idx, wr_raw, wr_dat, blank, dim,
    input  hex_seg, hex_sel
  );

  modport slave (
    input  ena_tick, wr_stb, wr_idx, wr_raw, wr_dat, blank, dim,
    output hex_seg, hex_sel
  );
endinterface

// File: rtl/wbc_hex_dec.sv
// Combinational digit decoder: hex nibble + dp, or raw segments passed through.
// Output is logical (1 = segment lit), polarity is applied by the user.
module wbc_hex_dec
  import wbc_hex_scan_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  input  logic       raw_i,
  input  logic [7:0] dat_i,
  output logic [7:0] seg_o
);
  always_comb begin
    seg_o = SEG_OFF;
    if (raw_i) begin
      seg_o = dat_i;
    end else begin
      seg_o         = HEX_LUT[nib_i];
      seg_o[SEG_DP] = dp_i;
    end
  end
endmodule

// File: rtl/wbc_hex_scan.sv
// Multiplexed seven-segment scanner: per-digit register file, slot scan on
// ena_tick with a one-cycle dark guard, PWM dimming and per-digit blanking.
module wbc_hex_scan
  import wbc_hex_scan_pkg::*;
#(
  parameter int DIGITS   = 3,
  parameter int DIM_BITS = 3,
  parameter bit SEG_ACT  = 1'b0,
  parameter bit SEL_ACT  = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  wbc_hex_scan_if.slave bus
);
  localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  digit_t [DIGITS-1:0]      regf_q;
  logic [DIGITS-1:0][7:0]   lane_seg;
  logic [SLOT_W-1:0]        slot_q, slot_d;
  logic [DIM_BITS-1:0]      phase_q;
  logic [7:0]               seg_q, seg_d;
  logic [DIGITS-1:0]        sel_q, sel_d;
  logic                     lit;

  for (genvar g = 0; g < DIGITS; g++) begin : g_lane
    wbc_hex_dec u_dec (
      .nib_i (regf_q[g].dat[3:0]),
      .dp_i  (regf_q[g].dat[7]),
      .raw_i (regf_q[g].raw),
      .dat_i (regf_q[g].dat),
      .seg_o (lane_seg[g])
    );
  end

  always_comb begin
    slot_d = slot_q;
    if (bus.ena_tick)
      slot_d = (slot_q == SLOT_W'(DIGITS - 1)) ? '0 : slot_q + SLOT_W'(1);
  end

  assign lit = (phase_q <= bus.dim) && !bus.blank[slot_q];

  // The cycle that registers a slot change drives dark, so the old digit's
  // segments never appear under the new select (and vice versa).
  always_comb begin
    seg_d = SEG_OFF;
    sel_d = '0;
    if (!bus.ena_tick && lit) begin
      seg_d = lane_seg[slot_q];
      sel_d = DIGITS'(1) << slot_q;
    end
    seg_d = seg_d ^ {8{~SEG_ACT}};
    sel_d = sel_d ^ {DIGITS{~SEL_ACT}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regf_q  <= {DIGITS{DIGIT_RST}};
      slot_q  <= '0;
      phase_q <= '0;
      seg_q   <= {8{~SEG_ACT}};
      sel_q   <= {DIGITS{~SEL_ACT}};
    end else begin
      for (int i = 0; i < DIGITS; i++)
        if (bus.wr_stb && bus.wr_idx == 3'(i))
          regf_q[i] <= {bus.wr_raw, bus.wr_dat};
      slot_q  <= slot_d;
      phase_q <= phase_q + DIM_BITS'(1);
      seg_q   <= seg_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.hex_seg = seg_q;
  assign bus.hex_sel = sel_q;

endmodule

// File: tb/tb_wbc_hex_scan.sv
// Directed bench for wbc_hex_scan: a 3-digit active-low instance carries most
// scenarios, 1- and 8-digit active-high instances cover parameter extremes.
module tb_wbc_hex_scan;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  wbc_hex_scan_if #(.DIGITS(3), .DIM_BITS(3)) b3 ();
  wbc_hex_scan_if #(.DIGITS(1), .DIM_BITS(3)) b1 ();
  wbc_hex_scan_if #(.DIGITS(8), .DIM_BITS(3)) b8 ();

  wbc_hex_scan #(.DIGITS(3), .DIM_BITS(3), .SEG_ACT(1'b0), .SEL_ACT(1'b0))
    d3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
  wbc_hex_scan #(.DIGITS(1), .DIM_BITS(3), .SEG_ACT(1'b1), .SEL_ACT(1'b1))
    d1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  wbc_hex_scan #(.DIGITS(8), .DIM_BITS(3), .SEG_ACT(1'b1), .SEL_ACT(1'b1))
    d8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  // Active-low images of the three digits written in test_hex_decode.
  logic [7:0] exp_seg3 [3] = '{8'h80, 8'h08, 8'hB6};
  logic [2:0] exp_sel3 [3] = '{3'b110, 3'b101, 3'b011};

  task automatic wr3(input logic [2:0] idx, input logic raw, input logic [7:0] dat);
    @(posedge clk); #1;
    b3.wr_stb = 1'b1; b3.wr_idx = idx; b3.wr_raw = raw; b3.wr_dat = dat;
    @(posedge clk); #1;
    b3.wr_stb = 1'b0;
  endtask

  task automatic tick3();
    @(posedge clk); #1;
    b3.ena_tick = 1'b1;
    @(posedge clk); #1;
    b3.ena_tick = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({b3.hex_seg, b3.hex_sel} !== {8'hFF, 3'b111}) begin
      n_fail++; $display("FAIL reset_d3 got %h/%b want ff/111", b3.hex_seg, b3.hex_sel);
    end
    n_tests++;
    if ({b8.hex_seg, b8.hex_sel} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_d8 got %h/%b want 00/00000000", b8.hex_seg, b8.hex_sel);
    end
    n_tests++;
    if ({b1.hex_seg, b1.hex_sel} !== 9'h000) begin
      n_fail++; $display("FAIL reset_d1 got %h/%b want 00/0", b1.hex_seg, b1.hex_sel);
    end
    @(negedge clk); #2 rst_n = 1'b1;
  endtask

  task automatic test_idle();
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      n_tests++;
      if (b3.hex_seg !== 8'hFF) begin
        n_fail++; $display("FAIL idle_slot%0d seg got %h want ff", s, b3.hex_seg);
      end
      tick3();
      @(negedge clk);
    end
  endtask

  task automatic test_hex_decode();
    wr3(3'd0, 1'b0, 8'h08);
    wr3(3'd1, 1'b0, 8'h8A);
    wr3(3'd2, 1'b1, 8'h49);
    @(negedge clk); @(negedge clk);
    n_tests++;
    if ({b3.hex_seg, b3.hex_sel} !== {exp_seg3[0], exp_sel3[0]}) begin
      n_fail++; $display("FAIL hex_slot0 got %h/%b want %h/%b", b3.hex_seg, b3.hex_sel, exp_seg3[0], exp_sel3[0]);
    end
    for (int s = 1; s <= 3; s++) begin
      tick3();
      @(negedge clk);
      n_tests++;
      if ({b3.hex_seg, b3.hex_sel} !== {8'hFF, 3'b111}) begin
        n_fail++; $display("FAIL guard_to%0d got %h/%b want ff/111", s % 3, b3.hex_seg, b3.hex_sel);
      end
      @(negedge clk);
      n_tests++;
      if ({b3.hex_seg, b3.hex_sel} !== {exp_seg3[s % 3], exp_sel3[s % 3]}) begin
        n_fail++; $display("FAIL hex_slot%0d got %h/%b want %h/%b", s % 3, b3.hex_seg, b3.hex_sel, exp_seg3[s % 3], exp_sel3[s % 3]);
      end
    end
  endtask

  task automatic test_pwm();
    logic [2:0] dims [3]  = '{3'd1, 3'd7, 3'd7};
    logic [2:0] blanks [3] = '{3'b000, 3'b000, 3'b001};
    int want [3] = '{2, 8, 0};
    for (int k = 0; k < 3; k++) begin
      int cnt = 0;
      @(posedge clk); #1;
      b3.dim = dims[k]; b3.blank = blanks[k];
      @(negedge clk);
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (b3.hex_sel !== 3'b111) cnt++;
      end
      n_tests++;
      if (cnt != want[k]) begin
        n_fail++; $display("FAIL pwm_case%0d lit cycles got %0d want %0d", k, cnt, want[k]);
      end
    end
    @(posedge clk); #1;
    b3.dim = 3'd7; b3.blank = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_bad_idx();
    wr3(3'd3, 1'b0, 8'h00);
    wr3(3'd4, 1'b0, 8'h00);
    wr3(3'd7, 1'b1, 8'hFF);
    @(negedge clk); @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      n_tests++;
      if (b3.hex_seg !== exp_seg3[s]) begin
        n_fail++; $display("FAIL badidx_slot%0d got %h want %h", s, b3.hex_seg, exp_seg3[s]);
      end
      tick3();
      @(negedge clk); @(negedge clk);
    end
  endtask

  task automatic test_write_tick();
    @(posedge clk); #1;
    b3.wr_stb = 1'b1; b3.wr_idx = 3'd1; b3.wr_raw = 1'b0; b3.wr_dat = 8'h05;
    b3.ena_tick = 1'b1;
    @(posedge clk); #1;
    b3.wr_stb = 1'b0; b3.ena_tick = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({b3.hex_seg, b3.hex_sel} !== {8'hFF, 3'b111}) begin
      n_fail++; $display("FAIL wrtick_guard got %h/%b want ff/111", b3.hex_seg, b3.hex_sel);
    end
    @(negedge clk);
    n_tests++;
    if ({b3.hex_seg, b3.hex_sel} !== {8'h92, 3'b101}) begin
      n_fail++; $display("FAIL wrtick_slot1 got %h/%b want 92/101", b3.hex_seg, b3.hex_sel);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    b3.ena_tick = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++;
    if ({b3.hex_seg, b3.hex_sel} !== {8'hFF, 3'b111}) begin
      n_fail++; $display("FAIL b2b_guard1 got %h/%b want ff/111", b3.hex_seg, b3.hex_sel);
    end
    @(posedge clk); #1;
    b3.ena_tick = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({b3.hex_seg, b3.hex_sel} !== {8'hFF, 3'b111}) begin
      n_fail++; $display("FAIL b2b_guard2 got %h/%b want ff/111", b3.hex_seg, b3.hex_sel);
    end
    @(negedge clk);
    n_tests++;
    if ({b3.hex_seg, b3.hex_sel} !== {8'h80, 3'b110}) begin
      n_fail++; $display("FAIL b2b_slot0 got %h/%b want 80/110", b3.hex_seg, b3.hex_sel);
    end
  endtask

  task automatic test_live_write();
    wr3(3'd0, 1'b0, 8'h0C);
    @(negedge clk); @(negedge clk);
    n_tests++;
    if ({b3.hex_seg, b3.hex_sel} !== {8'hC6, 3'b110}) begin
      n_fail++; $display("FAIL live_write got %h/%b want c6/110", b3.hex_seg, b3.hex_sel);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({b3.hex_seg, b3.hex_sel} !== {8'hFF, 3'b111}) begin
      n_fail++; $display("FAIL midreset_async got %h/%b want ff/111", b3.hex_seg, b3.hex_sel);
    end
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (b3.hex_seg !== 8'hFF) begin
      n_fail++; $display("FAIL midreset_regfile seg got %h want ff", b3.hex_seg);
    end
  endtask

  task automatic test_sweep();
    @(posedge clk); #1;
    b8.wr_stb = 1'b1; b8.wr_idx = 3'd7; b8.wr_raw = 1'b0; b8.wr_dat = 8'h0F;
    b1.wr_stb = 1'b1; b1.wr_idx = 3'd0; b1.wr_raw = 1'b0; b1.wr_dat = 8'h01;
    @(posedge clk); #1;
    b8.wr_idx = 3'd0; b8.wr_raw = 1'b1; b8.wr_dat = 8'h81;
    b1.wr_stb = 1'b0;
    @(posedge clk); #1;
    b8.wr_stb = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({b1.hex_seg, b1.hex_sel} !== {8'h06, 1'b1}) begin
      n_fail++; $display("FAIL d1_digit got %h/%b want 06/1", b1.hex_seg, b1.hex_sel);
    end
    for (int t = 0; t < 7; t++) begin
      @(posedge clk); #1 b8.ena_tick = 1'b1;
      @(posedge clk); #1 b8.ena_tick = 1'b0;
    end
    @(negedge clk); @(negedge clk);
    n_tests++;
    if ({b8.hex_seg, b8.hex_sel} !== {8'h71, 8'h80}) begin
      n_fail++; $display("FAIL d8_slot7 got %h/%b want 71/10000000", b8.hex_seg, b8.hex_sel);
    end
    @(posedge clk); #1 b8.ena_tick = 1'b1; b1.ena_tick = 1'b1;
    @(posedge clk); #1 b8.ena_tick = 1'b0; b1.ena_tick = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({b8.hex_seg, b8.hex_sel, b1.hex_seg, b1.hex_sel} !== 25'h0) begin
      n_fail++; $display("FAIL sweep_guard got d8 %h/%b d1 %h/%b want all zero", b8.hex_seg, b8.hex_sel, b1.hex_seg, b1.hex_sel);
    end
    @(negedge clk);
    n_tests++;
    if ({b8.hex_seg, b8.hex_sel} !== {8'h81, 8'h01}) begin
      n_fail++; $display("FAIL d8_wrap got %h/%b want 81/00000001", b8.hex_seg, b8.hex_sel);
    end
    n_tests++;
    if ({b1.hex_seg, b1.hex_sel} !== {8'h06, 1'b1}) begin
      n_fail++; $display("FAIL d1_after_tick got %h/%b want 06/1", b1.hex_seg, b1.hex_sel);
    end
  endtask

  initial begin
    b3.ena_tick = 1'b0; b3.wr_stb = 1'b0; b3.wr_idx = '0; b3.wr_raw = 1'b0;
    b3.wr_dat = '0; b3.blank = '0; b3.dim = 3'd7;
    b1.ena_tick = 1'b0; b1.wr_stb = 1'b0; b1.wr_idx = '0; b1.wr_raw = 1'b0;
    b1.wr_dat = '0; b1.blank = '0; b1.dim = 3'd7;
    b8.ena_tick = 1'b0; b8.wr_stb = 1'b0; b8.wr_idx = '0; b8.wr_raw = 1'b0;
    b8.wr_dat = '0; b8.blank = '0; b8.dim = 3'd7;
    test_reset();
    test_idle();
    test_hex_decode();
    test_pwm();
    test_bad_idx();
    test_write_tick();
    test_back_to_back();
    test_live_write();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1);
  end
endmodule
